// File: rtl/adc_frame_serializer_pkg.sv
// Shared types and sizing helpers for the ADC frame serializer.
// Used by adc_frame_serializer (optional timestamp port via ADC_FRAME_TIMESTAMP_EN).
package adc_fmt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DROP_W  = 16;
    localparam int STAMP_W = 32;

    // Channel index width; a single-bit index is kept even for tiny frames.
    function automatic int chan_w(input int channels);
        return ($clog2(channels) < 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/adc_frame_serializer_bit_reverse_lane.sv
// Combinational bit-order reversal of one ADC sample (or straight pass-through).
module bit_reverse_lane #(
    parameter int WIDTH   = 14,
    parameter bit REVERSE = 1'b1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (REVERSE) begin : g_rev
            assign dout[gi] = din[WIDTH-1-gi];
        end else begin : g_pass
            assign dout[gi] = din[gi];
        end
    end

endmodule

// File: rtl/adc_frame_serializer.sv
// Latches a multi-channel ADC frame, formats each lane and streams it out one sample per beat.
// Define ADC_FRAME_TIMESTAMP_EN to add a free-running cycle counter and the out_stamp port.
module adc_frame_serializer
    import adc_fmt_pkg::*;
#(
    parameter int                  WIDTH        = 14,
    parameter int                  CHANNELS     = 8,
    parameter logic [CHANNELS-1:0] REVERSE_MASK = {CHANNELS{1'b1}},
    localparam int                 CHAN_W       = chan_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      twos_comp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CHAN_W-1:0]         out_chan,
    output logic                      out_last,
    output logic [DROP_W-1:0]         drop_count
`ifdef ADC_FRAME_TIMESTAMP_EN
    ,
    output logic [STAMP_W-1:0]        out_stamp
`endif
);

    localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(CHANNELS - 1);

    logic [WIDTH-1:0] lane_out   [CHANNELS];
    logic [WIDTH-1:0] fmt_sample [CHANNELS];

    state_e              state_q, state_d;
    logic [CHAN_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]    frame_q [CHANNELS];
    logic [WIDTH-1:0]    frame_d [CHANNELS];
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                latch;
    logic                sending;
    logic                handshake;
    logic                final_handshake;

    // Reversal first, then the optional MSB flip turns offset-binary into two's complement.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        bit_reverse_lane #(
            .WIDTH   (WIDTH),
            .REVERSE (REVERSE_MASK[gi])
        ) u_lane (
            .din  (in_data[gi*WIDTH +: WIDTH]),
            .dout (lane_out[gi])
        );
        assign fmt_sample[gi] = lane_out[gi] ^ {twos_comp, {(WIDTH-1){1'b0}}};
    end

    assign sending         = (state_q == SEND);
    assign handshake       = sending && out_ready;
    assign final_handshake = handshake && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        latch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    latch = 1'b1;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        if (in_valid) begin
                            latch = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                // A frame arriving while the current one is still draining is lost.
                if (in_valid && !final_handshake && (drop_q != {DROP_W{1'b1}})) begin
                    drop_d = drop_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            frame_d = fmt_sample;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '{default: '0};
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = sending;
    assign out_data   = sending ? frame_q[idx_q] : '0;
    assign out_chan   = sending ? idx_q : '0;
    assign out_last   = sending && (idx_q == LAST_IDX);
    assign drop_count = drop_q;

`ifdef ADC_FRAME_TIMESTAMP_EN
    logic [STAMP_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        stamp_d     = latch ? cycle_cnt_q : stamp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            stamp_q     <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stamp_q     <= stamp_d;
        end
    end

    assign out_stamp = stamp_q;
`endif

endmodule
